// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
package pearl_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {IDLE, REQ, RSP, DRAIN, DONE} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Unlisted funct3 codes fall back to a word access; BU/HU exist only for loads.
  function automatic lsu_size_t op_size(input logic [2:0] op, input logic store);
    if (op == F3_B || (!store && op == F3_BU)) return SZ_B;
    if (op == F3_H || (!store && op == F3_HU)) return SZ_H;
    return SZ_W;
  endfunction
endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/response bus between the LSU and memory.
interface mem_stage_lsu_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                  input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i);
  modport slave  (input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                  output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: enables, replicated store data, alignment check, load extraction.
module lsu_align
  import pearl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic        store,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);
  lsu_size_t   sz;
  logic [31:0] shifted;

  assign sz      = op_size(op, store);
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    be         = 4'b1111;
    wdata      = rs2;
    misaligned = |offset;
    load_data  = rdata;
    case (sz)
      SZ_B: begin
        be         = 4'b0001 << offset;
        wdata      = {4{rs2[7:0]}};
        misaligned = 1'b0;
        load_data  = op[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be         = 4'b0011 << {offset[1], 1'b0};
        wdata      = {2{rs2[15:0]}};
        misaligned = offset[0];
        load_data  = op[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: captures an aligned access, runs it on the dmem bus, stalls until done.
module mem_stage_lsu
  import pearl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush_i,
  input  logic [31:0]   alu_result_mem,
  input  logic [31:0]   rs2_data_mem,
  input  logic [2:0]    mem_op_mem,
  input  logic          is_load_mem,
  input  logic          is_store_mem,
  mem_stage_lsu_if.master dmem,
  output logic          stall_o,
  output logic [31:0]   load_data_o,
  output logic          misaligned_o,
  output logic          bus_err_o
);
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  lsu_state_t  state, nxt;
  logic [31:0] addr_q, wdata_q, load_data_q;
  logic [3:0]  be_q;
  logic [2:0]  op_q;
  logic        we_q, flush_pend;
  logic [7:0]  cnt;

  logic        access, use_live, go, timeout, eflush, tmo_err;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld;
  logic        al_mis;

  assign access   = is_load_mem | is_store_mem;
  assign use_live = (state == IDLE);
  assign go       = use_live & access & ~flush_i & ~al_mis;
  assign timeout  = (cnt == TMO);
  // A flush that lost to a load grant is remembered and honoured in RSP.
  assign eflush   = flush_i | flush_pend;

  // Live inputs steer lanes in IDLE; captured ones drive extraction during RSP.
  lsu_align u_align (
    .op         (use_live ? mem_op_mem : op_q),
    .store      (use_live ? is_store_mem : we_q),
    .offset     (use_live ? alu_result_mem[1:0] : addr_q[1:0]),
    .rs2        (rs2_data_mem),
    .rdata      (dmem.dmem_rdata_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .misaligned (al_mis),
    .load_data  (al_ld)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      op_q        <= '0;
      we_q        <= 1'b0;
      flush_pend  <= 1'b0;
      load_data_q <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)                    cnt <= '0;
      else if (state == REQ || state == RSP) cnt <= cnt + 8'd1;
      if (go) begin
        addr_q  <= alu_result_mem;
        wdata_q <= al_wdata;
        be_q    <= al_be;
        op_q    <= mem_op_mem;
        we_q    <= is_store_mem;
      end
      if (state == REQ)      flush_pend <= dmem.dmem_gnt_i & flush_i & ~we_q;
      else if (state != RSP) flush_pend <= 1'b0;
      if (state == RSP && dmem.dmem_rvalid_i && !eflush) load_data_q <= al_ld;
    end
  end

  always_comb begin
    nxt     = state;
    tmo_err = 1'b0;
    case (state)
      IDLE:  if (go) nxt = REQ;
      REQ: begin
        if (dmem.dmem_gnt_i)  nxt = we_q ? DONE : RSP;
        else if (flush_i)     nxt = IDLE;
        else if (timeout) begin
          nxt     = IDLE;
          tmo_err = 1'b1;
        end
      end
      RSP: begin
        // Response and kill together: data is consumed and dropped, nothing to drain.
        if (dmem.dmem_rvalid_i) nxt = eflush ? IDLE : DONE;
        else if (eflush)        nxt = DRAIN;
        else if (timeout) begin
          nxt     = IDLE;
          tmo_err = 1'b1;
        end
      end
      DRAIN: if (dmem.dmem_rvalid_i) nxt = IDLE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem.dmem_req_o   = (state == REQ);
    dmem.dmem_we_o    = we_q;
    dmem.dmem_addr_o  = {addr_q[31:2], 2'b00};
    dmem.dmem_be_o    = be_q;
    dmem.dmem_wdata_o = wdata_q;
    stall_o           = go || state == REQ || state == RSP || state == DRAIN;
    misaligned_o      = use_live & access & ~flush_i & al_mis;
    bus_err_o         = tmo_err;
    load_data_o       = load_data_q;
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a scoreboard of expected bus transactions.
module tb_mem_stage_lsu;
  import pearl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] alu_result_mem = '0;
  logic [31:0] rs2_data_mem = '0;
  logic [2:0]  mem_op_mem = '0;
  logic        is_load_mem = 1'b0;
  logic        is_store_mem = 1'b0;
  logic        stall_o, misaligned_o, bus_err_o;
  logic [31:0] load_data_o;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .flush_i        (flush_i),
    .alu_result_mem (alu_result_mem),
    .rs2_data_mem   (rs2_data_mem),
    .mem_op_mem     (mem_op_mem),
    .is_load_mem    (is_load_mem),
    .is_store_mem   (is_store_mem),
    .dmem           (bus),
    .stall_o        (stall_o),
    .load_data_o    (load_data_o),
    .misaligned_o   (misaligned_o),
    .bus_err_o      (bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   err_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one MEM-stage instruction to completion; inputs change at posedge+1, sampling at negedge.
  task automatic run(input string tag, input bit ld, input bit st, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] rs2, input int gnt_dly,
                     input int rv_dly, input int flush_cyc, input logic [31:0] rdata,
                     input logic [3:0] exp_be, input logic [31:0] exp_wd, input int exp_stall,
                     input int exp_reqs, input int exp_mis, input int exp_err,
                     input logic [31:0] exp_ld);
    int stalls = 0, reqs = 0, mis = 0, errs = 0, gcnt = 0, rcnt = 0;
    bit granted = 0, kill = 0, finished = 0;
    txn_t t;
    if (exp_reqs > 0) begin
      t.addr = {addr[31:2], 2'b00}; t.be = exp_be; t.we = st; t.wdata = exp_wd;
      sb.push_back(t);
    end
    err_cyc = -1;
    is_load_mem = ld; is_store_mem = st; mem_op_mem = op;
    alu_result_mem = addr; rs2_data_mem = rs2;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (kill) begin is_load_mem = 1'b0; is_store_mem = 1'b0; end
      flush_i = (cyc == flush_cyc);
      @(negedge clk);
      bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = '0;
      if (flush_i) kill = 1;
      if (stall_o) stalls++;
      if (misaligned_o) mis++;
      if (bus_err_o) begin
        errs++; err_cyc = cyc;
        is_load_mem = 1'b0; is_store_mem = 1'b0;
      end
      if (bus.dmem_req_o) begin
        reqs++;
        if (sb.size() == 0) chk({tag, ".unexpected_req"}, 32'd1, 32'd0);
        else begin
          chk({tag, ".addr"},  bus.dmem_addr_o,  sb[0].addr);
          chk({tag, ".be"},    {28'd0, bus.dmem_be_o}, {28'd0, sb[0].be});
          chk({tag, ".we"},    {31'd0, bus.dmem_we_o}, {31'd0, sb[0].we});
          chk({tag, ".wdata"}, bus.dmem_wdata_o, sb[0].wdata);
          if (gcnt == gnt_dly) begin
            bus.dmem_gnt_i = 1'b1; granted = 1;
            void'(sb.pop_front());
          end
        end
        gcnt++;
      end else if (granted && ld) begin
        if (rcnt == rv_dly) begin bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = rdata; end
        rcnt++;
      end
      if (!stall_o) begin finished = 1; break; end
      @(posedge clk); #1;
    end
    if (!finished) chk({tag, ".stall_never_released"}, 32'd1, 32'd0);
    chk({tag, ".stall_cycles"}, stalls, exp_stall);
    chk({tag, ".req_cycles"},   reqs,   exp_reqs);
    chk({tag, ".mis_pulses"},   mis,    exp_mis);
    chk({tag, ".err_pulses"},   errs,   exp_err);
    chk({tag, ".load_data"},    load_data_o, exp_ld);
    if (sb.size() != 0) void'(sb.pop_front());  // request dropped by flush
    @(posedge clk); #1;
    is_load_mem = 1'b0; is_store_mem = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_stall"}, {31'd0, stall_o},          32'd0);
    chk({tag, ".idle_req"},   {31'd0, bus.dmem_req_o},   32'd0);
    chk({tag, ".idle_mis"},   {31'd0, misaligned_o},     32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.req",   {31'd0, bus.dmem_req_o}, 32'd0);
    chk("rst.we",    {31'd0, bus.dmem_we_o},  32'd0);
    chk("rst.addr",  bus.dmem_addr_o,          32'd0);
    chk("rst.be",    {28'd0, bus.dmem_be_o},   32'd0);
    chk("rst.wdata", bus.dmem_wdata_o,         32'd0);
    chk("rst.stall", {31'd0, stall_o},         32'd0);
    chk("rst.ldata", load_data_o,              32'd0);
    chk("rst.mis",   {31'd0, misaligned_o},    32'd0);
    chk("rst.err",   {31'd0, bus_err_o},       32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    //  tag      ld st op     addr          rs2           g  rv fl rdata         be       wdata         st rq mi er load_data
    run("lw",    1, 0, F3_W,  32'h100, 32'h0,        0, 0, -1, 32'hDEADBEEF, 4'b1111, 32'h0,        3, 1, 0, 0, 32'hDEADBEEF);
    run("lb",    1, 0, F3_B,  32'h103, 32'h0,        0, 0, -1, 32'h80FF0011, 4'b1000, 32'h0,        3, 1, 0, 0, 32'hFFFFFF80);
    run("lbu",   1, 0, F3_BU, 32'h103, 32'h0,        0, 0, -1, 32'h80FF0011, 4'b1000, 32'h0,        3, 1, 0, 0, 32'h00000080);
    run("lh",    1, 0, F3_H,  32'h102, 32'h0,        1, 2, -1, 32'h80FF0011, 4'b1100, 32'h0,        6, 2, 0, 0, 32'hFFFF80FF);
    run("lhu",   1, 0, F3_HU, 32'h100, 32'h0,        0, 0, -1, 32'h80FF8011, 4'b0011, 32'h0,        3, 1, 0, 0, 32'h00008011);
    run("sh",    0, 1, F3_H,  32'h202, 32'h1234ABCD, 4, 0, -1, 32'h0,        4'b1100, 32'hABCDABCD, 6, 5, 0, 0, 32'h00008011);
    run("sb",    0, 1, F3_B,  32'h001, 32'h000000CD, 0, 0, -1, 32'h0,        4'b0010, 32'hCDCDCDCD, 2, 1, 0, 0, 32'h00008011);
    run("sw",    0, 1, F3_W,  32'h300, 32'hCAFEF00D, 0, 0, -1, 32'h0,        4'b1111, 32'hCAFEF00D, 2, 1, 0, 0, 32'h00008011);
    run("lw_mis",1, 0, F3_W,  32'h101, 32'h0,        0, 0, -1, 32'h0,        4'b0000, 32'h0,        0, 0, 1, 0, 32'h00008011);
    run("sh_mis",0, 1, F3_H,  32'h203, 32'h0,        0, 0, -1, 32'h0,        4'b0000, 32'h0,        0, 0, 1, 0, 32'h00008011);
    run("lw_011",1, 0, 3'b011,32'h104, 32'h0,        0, 0, -1, 32'h13579BDF, 4'b1111, 32'h0,        3, 1, 0, 0, 32'h13579BDF);
    run("fl_req",1, 0, F3_W,  32'h108, 32'h0,        9, 0,  1, 32'h0,        4'b1111, 32'h0,        2, 1, 0, 0, 32'h13579BDF);
    run("fl_rsp",1, 0, F3_W,  32'h10C, 32'h0,        0, 2,  2, 32'h55555555, 4'b1111, 32'h0,        5, 1, 0, 0, 32'h13579BDF);
    run("tmo",   1, 0, F3_W,  32'h110, 32'h0,        0, -1,-1, 32'h0,        4'b1111, 32'h0,       11, 1, 0, 1, 32'h13579BDF);
    chk("tmo.err_cycle", err_cyc, 10);
    run("lw_post",1,0, F3_W,  32'h114, 32'h0,        0, 0, -1, 32'h0BADF00D, 4'b1111, 32'h0,        3, 1, 0, 0, 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
